// File: rtl/stopwatch_display_if.sv
// Bundle between the upstream time counter and the multiplexed 4-digit display.
interface stopwatch_display_if;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (output minutes, seconds, adj, sel, input seg, an, dp);
    modport slave  (input minutes, seconds, adj, sel, output seg, an, dp);
endinterface

// File: rtl/stopwatch_display.sv
// MM:SS multiplexed 7-segment driver with per-frame capture, clamping and
// field blinking for adjust mode. All outputs are active-low and registered.
module stopwatch_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_display_if.slave  bus
);
    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] r_refresh_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;
    logic [1:0]    r_digit;
    logic [5:0]    r_cap_min;
    logic [5:0]    r_cap_sec;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_refresh_wrap;
    logic          w_blink_wrap;
    logic          w_frame_wrap;
    logic          w_blank;
    logic [3:0]    w_digit_val;

    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_refresh_wrap = (r_refresh_cnt == REFRESH_LAST);
    assign w_blink_wrap   = (r_blink_cnt == BLINK_LAST);
    assign w_frame_wrap   = w_refresh_wrap && (r_digit == 2'd3);

    // digit[1] distinguishes the minutes field (2,3) from the seconds field (0,1)
    assign w_blank = bus.adj && r_blink_ph && (bus.sel ? ~r_digit[1] : r_digit[1]);

    always_comb begin
        w_digit_val = 4'd0;
        case (r_digit)
            2'd0:    w_digit_val = 4'(r_cap_sec % 6'd10);
            2'd1:    w_digit_val = 4'(r_cap_sec / 6'd10);
            2'd2:    w_digit_val = 4'(r_cap_min % 6'd10);
            default: w_digit_val = 4'(r_cap_min / 6'd10);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_blink_cnt   <= '0;
            r_blink_ph    <= 1'b0;
            r_digit       <= 2'd0;
            r_cap_min     <= 6'd0;
            r_cap_sec     <= 6'd0;
            r_an          <= 4'hF;
            r_seg         <= 7'h7F;
            r_dp          <= 1'b1;
        end else begin
            r_refresh_cnt <= w_refresh_wrap ? '0 : r_refresh_cnt + RW'(1);
            r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
            if (w_blink_wrap) r_blink_ph <= ~r_blink_ph;
            if (w_refresh_wrap) r_digit <= r_digit + 2'd1;
            // Snapshot inputs only at frame boundaries so a frame is never torn
            if (w_frame_wrap) begin
                r_cap_min <= clamp59(bus.minutes);
                r_cap_sec <= clamp59(bus.seconds);
            end
            r_an  <= w_blank ? 4'hF  : ~(4'b0001 << r_digit);
            r_seg <= w_blank ? 7'h7F : seg_encode(w_digit_val);
            r_dp  <= ~((r_digit == 2'd2) && !w_blank);
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display against a cycle-index reference model.
module tb_stopwatch_display;
    localparam int unsigned R     = 4;
    localparam int unsigned B     = 16;
    localparam int unsigned FRAME = 4 * R;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_display_if bus();

    stopwatch_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: k = cycles since reset release, cap_* = displayed frame values
    int k       = 0;
    int cap_min = 0;
    int cap_sec = 0;

    logic [6:0] seg_tab [10];
    logic [3:0] lit_an  [4];
    logic [6:0] lit_seg [4];
    logic       lit_dp  [4];

    function automatic logic [11:0] model_out();
        int d;
        int v;
        bit blank;
        logic [3:0] a;
        if (rst) return 12'hFFF;
        d = int'((k / R) % 4);
        case (d)
            0:       v = cap_sec % 10;
            1:       v = cap_sec / 10;
            2:       v = cap_min % 10;
            default: v = cap_min / 10;
        endcase
        blank = bus.adj && (((k / B) % 2) == 1) && (bus.sel ? (d < 2) : (d >= 2));
        if (blank) return 12'hFFF;
        a = 4'hF;
        a[d] = 1'b0;
        return {a, seg_tab[v], (d == 2) ? 1'b0 : 1'b1};
    endfunction

    task automatic model_advance();
        if (rst) begin
            k = 0; cap_min = 0; cap_sec = 0;
        end else begin
            if ((k % FRAME) == FRAME - 1) begin
                cap_min = (bus.minutes > 6'd59) ? 59 : int'(bus.minutes);
                cap_sec = (bus.seconds > 6'd59) ? 59 : int'(bus.seconds);
            end
            k++;
        end
    endtask

    task automatic step(output logic [11:0] exp, output logic [11:0] got);
        exp = model_out();
        @(posedge clk);
        #1;
        got = {bus.an, bus.seg, bus.dp};
        model_advance();
    endtask

    task automatic align_frame();
        logic [11:0] e, g;
        for (int i = 0; i < int'(FRAME) && (k % FRAME) != 0; i++) step(e, g);
    endtask

    task automatic test_reset();
        logic [11:0] e, g;
        rst = 1'b1;
        bus.minutes = 6'd12; bus.seconds = 6'd34; bus.adj = 1'b0; bus.sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(e, g);
            checks++;
            if (g !== 12'hFFF) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, g, 12'hFFF);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < int'(FRAME); i++) begin
            step(e, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_first_frame cyc=%0d got=%b exp=%b", i, g, e);
            end
            if (i == 0) begin
                checks++;
                if (g !== {4'b1110, 7'b1000000, 1'b1}) begin
                    failures++;
                    $display("FAIL reset_release got=%b exp=%b", g, {4'b1110, 7'b1000000, 1'b1});
                end
            end
        end
    endtask

    task automatic test_normal_scan();
        logic [11:0] e, g;
        int kb;
        bus.minutes = 6'd12; bus.seconds = 6'd34; bus.adj = 1'b0;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            kb = k;
            step(e, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL scan_model k=%0d got=%b exp=%b", kb, g, e);
            end
            if (kb >= int'(FRAME)) begin
                checks++;
                if (g !== {lit_an[(kb / R) % 4], lit_seg[(kb / R) % 4], lit_dp[(kb / R) % 4]}) begin
                    failures++;
                    $display("FAIL scan_literal k=%0d got=%b exp=%b", kb, g,
                             {lit_an[(kb / R) % 4], lit_seg[(kb / R) % 4], lit_dp[(kb / R) % 4]});
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [11:0] e, g;
        int kb;
        logic [6:0] want;
        align_frame();
        bus.minutes = 6'd63; bus.seconds = 6'd60;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            kb = k;
            step(e, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL clamp_model k=%0d got=%b exp=%b", kb, g, e);
            end
            if (i >= int'(FRAME)) begin
                want = (((kb / R) % 2) == 0) ? 7'b0010000 : 7'b0010010;
                checks++;
                if (g[7:1] !== want) begin
                    failures++;
                    $display("FAIL clamp_digit k=%0d got=%b exp=%b", kb, g[7:1], want);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] e, g;
        int kb;
        int blank_hi;
        int blank_lo;
        bus.minutes = 6'd12; bus.seconds = 6'd34;
        for (int m = 0; m < 3; m++) begin
            bus.adj = (m != 2);
            bus.sel = (m == 1);
            blank_hi = 0; blank_lo = 0;
            for (int i = 0; i < int'(4 * B); i++) begin
                kb = k;
                step(e, g);
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL blink_model mode=%0d k=%0d got=%b exp=%b", m, kb, g, e);
                end
                if (g[11:8] == 4'hF) begin
                    if (((kb / R) % 4) >= 2) blank_hi++;
                    else blank_lo++;
                end
            end
            checks++;
            if ((m == 0 && (blank_hi == 0 || blank_lo != 0)) ||
                (m == 1 && (blank_lo == 0 || blank_hi != 0)) ||
                (m == 2 && (blank_lo != 0 || blank_hi != 0))) begin
                failures++;
                $display("FAIL blink_fields mode=%0d got hi=%0d lo=%0d", m, blank_hi, blank_lo);
            end
        end
        bus.adj = 1'b0; bus.sel = 1'b0;
    endtask

    task automatic test_mid_frame_change();
        logic [11:0] e, g;
        int kb;
        bus.seconds = 6'd34;
        align_frame();
        align_frame();
        for (int i = 0; i < int'(3 * FRAME); i++) begin
            kb = k;
            if (i == int'(FRAME + R + 1)) bus.seconds = 6'd35;
            step(e, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL midframe_model k=%0d got=%b exp=%b", kb, g, e);
            end
            if (i == int'(FRAME + R + 2)) begin
                checks++;
                if (g[7:1] !== 7'b0110000) begin
                    failures++;
                    $display("FAIL midframe_hold got=%b exp=%b", g[7:1], 7'b0110000);
                end
            end
            if (i == int'(2 * FRAME)) begin
                checks++;
                if (g[7:1] !== 7'b0010010) begin
                    failures++;
                    $display("FAIL midframe_next got=%b exp=%b", g[7:1], 7'b0010010);
                end
            end
        end
    endtask

    task automatic test_mid_scan_reset();
        logic [11:0] e, g;
        for (int i = 0; i < int'(FRAME) && !(((k / R) % 4) == 2 && (k % R) == 1); i++) step(e, g);
        rst = 1'b1;
        step(e, g);
        checks++;
        if (g !== 12'hFFF) begin
            failures++;
            $display("FAIL midscan_reset got=%b exp=%b", g, 12'hFFF);
        end
        rst = 1'b0;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            step(e, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL midscan_model cyc=%0d got=%b exp=%b", i, g, e);
            end
            if (i == 0) begin
                checks++;
                if (g !== {4'b1110, 7'b1000000, 1'b1}) begin
                    failures++;
                    $display("FAIL midscan_restart got=%b exp=%b", g, {4'b1110, 7'b1000000, 1'b1});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] e, g;
        int kb;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) bus.minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) bus.seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 31) == 0) bus.adj = ~bus.adj;
            if ($urandom_range(0, 31) == 0) bus.sel = ~bus.sel;
            rst = ($urandom_range(0, 199) == 0);
            kb = k;
            step(e, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL random k=%0d got=%b exp=%b", kb, g, e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        lit_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        lit_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        bus.minutes = 6'd0; bus.seconds = 6'd0; bus.adj = 1'b0; bus.sel = 1'b0;
        #2;
        test_reset();
        test_normal_scan();
        test_clamp();
        test_blink();
        test_mid_frame_change();
        test_mid_scan_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clock cycles each digit is held; legal range >= 2.
REQ-002 Parameter: BLINK_DIV, 25000000, clock cycles per blink half-period; legal range >= 2.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: minutes  input  6  binary minutes value from the upstream counter.
REQ-006 Port: seconds  input  6  binary seconds value from the upstream counter.
REQ-007 Port: adj  input  1  adjust mode; 1 enables blinking of the selected field.
REQ-008 Port: sel  input  1  field select while adj=1: 0 = minutes, 1 = seconds.
REQ-009 Port: seg  output  7  active-low cathodes, packed as {g,f,e,d,c,b,a}; registered.
REQ-010 Port: an  output  4  active-low anodes; an[0] = seconds ones (rightmost), an[3] = minutes tens; registered.
REQ-011 Port: dp  output  1  active-low decimal point; registered.

Function
REQ-012 The block SHALL keep a refresh counter 0..REFRESH_DIV-1 that wraps to 0 after REFRESH_DIV-1.
REQ-013 The block SHALL keep a 2-bit digit index that advances 0->1->2->3->0 on the cycle the refresh counter is at REFRESH_DIV-1, so each digit is active exactly REFRESH_DIV cycles.
REQ-014 Digit mapping SHALL be: 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
REQ-015 The block SHALL hold captured copies of minutes and seconds, loaded only on the cycle the digit index wraps 3->0; input changes at any other time SHALL NOT affect the frame in progress.
REQ-016 A captured value greater than 59 SHALL be clamped to 59 at capture.
REQ-017 Tens digit SHALL be value/10 and ones digit SHALL be value%10, each 0..9.
REQ-018 Segment encoding {g..a} SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Outputs SHALL have one cycle of latency: an/seg/dp in cycle t reflect the digit index, captured values, and blink state in cycle t-1.
REQ-020 For active digit d, an SHALL drive only bit d low; seg SHALL carry that digit's encoding.
REQ-021 dp SHALL be 0 only while digit 2 is active and not blanked; otherwise 1.
REQ-022 The block SHALL keep a blink counter 0..BLINK_DIV-1 and a blink phase bit that toggles on the cycle the counter is at BLINK_DIV-1.
REQ-023 When adj=1 and blink phase=1, digits of the selected field (sel=0: digits 2,3; sel=1: digits 0,1) SHALL be blanked: an all 1s, seg=1111111, dp=1.
REQ-024 When adj=0, no digit SHALL ever be blanked, regardless of blink phase; the blink counter SHALL continue running.
REQ-025 adj and sel SHALL take effect on the next output register update; they SHALL NOT be captured per frame.

Reset
REQ-026 While rst=1: an=1111, seg=1111111, dp=1; refresh counter, blink counter, digit index, and blink phase = 0; captured minutes and seconds = 0.
REQ-027 rst SHALL take priority over every other input in the same cycle, including mid-scan and mid-blink.
REQ-028 In the first cycle after rst deasserts, the outputs SHALL show digit 0 of 00:00: an=1110, seg=1000000. New inputs SHALL first appear after the first 3->0 wrap.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-029 Reset: rst=1 for 3 cycles -> an=1111, seg=1111111, dp=1 throughout; release -> first frame 00:00, with each digit held 4 cycles.
REQ-030 Normal scan: minutes=12, seconds=34, adj=0; after first wrap the outputs SHALL cycle an=1110 seg=0011001, an=1101 seg=0110000, an=1011 seg=0100100 dp=0, an=0111 seg=1111001.
REQ-031 Clamp: minutes=63, seconds=60 -> minutes digits and seconds digits SHALL each show 5 then 9 (seg 0010010, 0010000).
REQ-032 Blink: adj=1, sel=0 -> digits 2,3 blanked (an=1111) during the 16-cycle phase=1 windows and shown during phase=0; digits 0,1 never blanked. Repeating with sel=1 SHALL swap the fields; adj=0 SHALL produce no blanking.
REQ-033 Mid-frame change: change seconds from 34 to 35 while digit 1 is active -> the remainder of the frame still shows 34; the next frame shows 35.
REQ-034 Mid-scan reset: assert rst for 1 cycle while digit 2 is active -> the next cycle an=1111; after release the scan restarts at digit 0 showing 00:00.
